// File: rtl/a1335_poll_scheduler_pkg.sv
// Shared constants and state encoding for the A1335 poll scheduler slice.
package a1335_poll_scheduler_pkg;

  localparam int A1335_ANGLE_BITS = 12;
  localparam int A1335_ADDR_W     = 7;
  localparam int A1335_ANGLE_W    = 16;
  localparam int POS_W            = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQUEST   = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_UPDATE    = 3'd4,
    ST_RECOVER   = 3'd5,
    ST_NEXT      = 3'd6
  } poll_state_e;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/a1335_poll_scheduler_if.sv
// Handshake between the poll scheduler and the shared A1335 angle controller.
interface a1335_poll_scheduler_if;
  import a1335_poll_scheduler_pkg::*;

  logic                     read_angle;
  logic [A1335_ADDR_W-1:0]  device_id;
  logic                     done;
  logic [A1335_ANGLE_W-1:0] angle;

  modport master (output read_angle, device_id, input done, angle);
  modport slave  (input read_angle, device_id, output done, angle);

endinterface

// File: rtl/a1335_poll_scheduler_angle_unwrap.sv
// Per-sensor multi-turn unwrap: shortest-path delta between successive angles,
// accumulated into a wrapping signed position.
module a1335_poll_scheduler_angle_unwrap
  import a1335_poll_scheduler_pkg::*;
#(
  parameter int ANGLE_BITS = A1335_ANGLE_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  update,
  input  logic                  zero,
  input  logic [ANGLE_BITS-1:0] angle,
  output logic                  valid,
  output logic [POS_W-1:0]      position
);

  logic [ANGLE_BITS-1:0] last_r;
  logic [ANGLE_BITS-1:0] delta_s;
  logic [POS_W-1:0]      delta_ext_s;
  logic [POS_W-1:0]      pos_r;
  logic                  valid_r;

  // Modular difference reinterpreted as signed, then sign-extended
  always_comb begin
    delta_s     = angle - last_r;
    delta_ext_s = {{(POS_W-ANGLE_BITS){delta_s[ANGLE_BITS-1]}}, delta_s};
  end

  // Position/last registers; a zero request beats the accumulated delta
  always_ff @(posedge clock) begin
    if (reset) begin
      last_r  <= '0;
      pos_r   <= '0;
      valid_r <= 1'b0;
    end else if (update) begin
      last_r  <= angle;
      valid_r <= 1'b1;
      if (!valid_r || zero) begin
        pos_r <= '0;
      end else begin
        pos_r <= pos_r + delta_ext_s;
      end
    end else if (zero) begin
      pos_r <= '0;
    end else begin
      pos_r <= pos_r;
    end
  end

  assign valid    = valid_r;
  assign position = pos_r;

endmodule

// File: rtl/a1335_poll_scheduler.sv
// Periodic sweep of NUM_SENSORS A1335 encoders through one shared controller,
// with per-transaction timeout, overrun detection and multi-turn unwrap.
module a1335_poll_scheduler
  import a1335_poll_scheduler_pkg::*;
#(
  parameter int NUM_SENSORS    = 4,
  parameter int CLOCK_FREQ     = 50000000,
  parameter int POLL_HZ        = 1000,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ANGLE_BITS     = A1335_ANGLE_BITS
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [A1335_ADDR_W*NUM_SENSORS-1:0] device_ids,
  input  logic                              clear_errors,
  input  logic [NUM_SENSORS-1:0]            zero_position,
  a1335_poll_scheduler_if.master            bus,
  output logic [POS_W*NUM_SENSORS-1:0]      position,
  output logic [A1335_ANGLE_W*NUM_SENSORS-1:0] raw_angle,
  output logic [NUM_SENSORS-1:0]            valid,
  output logic [NUM_SENSORS-1:0]            timeout_error,
  output logic                              overrun,
  output logic                              sweep_done
);

  localparam int TICK_DIV = CLOCK_FREQ / POLL_HZ;
  localparam int PRE_W    = clog2_min1(TICK_DIV);
  localparam int IDX_W    = clog2_min1(NUM_SENSORS);
  localparam int TMO_W    = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SENSORS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  poll_state_e              state_r, state_s;
  logic [PRE_W-1:0]         presc_r;
  logic                     tick_s;
  logic [IDX_W-1:0]         index_r, idx_nx_s;
  logic [TMO_W-1:0]         tmo_r;
  logic [A1335_ADDR_W-1:0]  device_id_r;
  logic                     sweep_done_r, overrun_r;
  logic [NUM_SENSORS-1:0]   timeout_r;
  logic [A1335_ANGLE_W-1:0] raw_r [NUM_SENSORS];
  logic [A1335_ADDR_W-1:0]  ids_s [NUM_SENSORS];
  logic read_angle_s, start_s, adv_s, sweep_end_s, update_s, tmo_hit_s, tmo_run_s;

  assign tick_s   = (presc_r == PRE_LAST);
  assign idx_nx_s = index_r + IDX_W'(1);

  // Free-running sweep-rate prescaler
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRE_W'(1);
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_s      = state_r;
    read_angle_s = 1'b0;
    start_s      = 1'b0;
    adv_s        = 1'b0;
    sweep_end_s  = 1'b0;
    update_s     = 1'b0;
    tmo_hit_s    = 1'b0;
    tmo_run_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && enable) begin
          start_s = 1'b1;
          state_s = ST_REQUEST;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQUEST: begin
        // A controller still finishing a pre-reset transaction holds us here
        if (bus.done) begin
          read_angle_s = 1'b1;
          state_s      = ST_WAIT_BUSY;
        end else begin
          state_s = ST_REQUEST;
        end
      end
      ST_WAIT_BUSY: begin
        tmo_run_s = 1'b1;
        if (!bus.done) begin
          state_s = ST_WAIT_DONE;
        end else if (tmo_r == TMO_LAST) begin
          tmo_hit_s = 1'b1;
          state_s   = ST_RECOVER;
        end else begin
          state_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        tmo_run_s = 1'b1;
        if (bus.done) begin
          state_s = ST_UPDATE;
        end else if (tmo_r == TMO_LAST) begin
          tmo_hit_s = 1'b1;
          state_s   = ST_RECOVER;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      ST_UPDATE: begin
        update_s = 1'b1;
        state_s  = ST_NEXT;
      end
      ST_RECOVER: begin
        if (bus.done) begin
          state_s = ST_NEXT;
        end else begin
          state_s = ST_RECOVER;
        end
      end
      ST_NEXT: begin
        if (index_r == IDX_LAST) begin
          sweep_end_s = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          adv_s   = 1'b1;
          state_s = ST_REQUEST;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, sensor index, timeout counter and sticky overrun
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      index_r      <= '0;
      tmo_r        <= '0;
      device_id_r  <= ids_s[0];
      sweep_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      sweep_done_r <= sweep_end_s;
      if (start_s) begin
        index_r     <= '0;
        device_id_r <= ids_s[0];
      end else if (adv_s) begin
        index_r     <= idx_nx_s;
        device_id_r <= ids_s[idx_nx_s];
      end else begin
        index_r     <= index_r;
        device_id_r <= device_id_r;
      end
      if (state_r == ST_REQUEST) begin
        tmo_r <= '0;
      end else if (tmo_run_s) begin
        tmo_r <= tmo_r + TMO_W'(1);
      end else begin
        tmo_r <= tmo_r;
      end
      if (tick_s && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end else if (clear_errors) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Sticky per-sensor timeout flags and raw angle capture
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (reset) begin
        timeout_r[i] <= 1'b0;
        raw_r[i]     <= '0;
      end else begin
        if (tmo_hit_s && (index_r == IDX_W'(i))) begin
          timeout_r[i] <= 1'b1;
        end else if (clear_errors) begin
          timeout_r[i] <= 1'b0;
        end else begin
          timeout_r[i] <= timeout_r[i];
        end
        if (update_s && (index_r == IDX_W'(i))) begin
          raw_r[i] <= bus.angle;
        end else begin
          raw_r[i] <= raw_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_sensor
    assign ids_s[g] = device_ids[A1335_ADDR_W*g +: A1335_ADDR_W];
    assign raw_angle[A1335_ANGLE_W*g +: A1335_ANGLE_W] = raw_r[g];

    a1335_poll_scheduler_angle_unwrap #(
      .ANGLE_BITS (ANGLE_BITS)
    ) u_unwrap (
      .clock    (clock),
      .reset    (reset),
      .update   (update_s && (index_r == IDX_W'(g))),
      .zero     (zero_position[g]),
      .angle    (bus.angle[ANGLE_BITS-1:0]),
      .valid    (valid[g]),
      .position (position[POS_W*g +: POS_W])
    );
  end

  assign bus.read_angle = read_angle_s;
  assign bus.device_id  = device_id_r;
  assign timeout_error  = timeout_r;
  assign overrun        = overrun_r;
  assign sweep_done     = sweep_done_r;

endmodule

// File: tb/tb_a1335_poll_scheduler.sv
// Directed bench: behavioural angle controller plus hand-computed expectations.
module tb_a1335_poll_scheduler;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          clear_errors;
  logic [27:0]   device_ids;
  logic [3:0]    zero_position;
  logic [127:0]  position;
  logic [63:0]   raw_angle;
  logic [3:0]    valid;
  logic [3:0]    timeout_error;
  logic          overrun;
  logic          sweep_done;

  a1335_poll_scheduler_if bus();

  a1335_poll_scheduler #(
    .NUM_SENSORS    (4),
    .CLOCK_FREQ     (200),
    .POLL_HZ        (1),
    .TIMEOUT_CYCLES (100),
    .ANGLE_BITS     (12)
  ) u_dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .device_ids    (device_ids),
    .clear_errors  (clear_errors),
    .zero_position (zero_position),
    .bus           (bus),
    .position      (position),
    .raw_angle     (raw_angle),
    .valid         (valid),
    .timeout_error (timeout_error),
    .overrun       (overrun),
    .sweep_done    (sweep_done)
  );

  always #5 clock = ~clock;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          latency      = 50;
  bit          hang_mode    = 1'b0;
  bit          zero_arm     = 1'b0;
  logic [15:0] angle_tab [4];
  logic [6:0]  cur_id;
  int          id_glitch    = 0;
  int          pulse_cnt    = 0;
  int          sweep_cnt    = 0;
  int          overlap_cnt  = 0;
  logic [27:0] ids_log      = 28'h0;
  logic        te_early     = 1'b1;
  logic        te_late      = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_cycle();
    @(negedge clock);
    if (bus.device_id !== cur_id) id_glitch++;
  endtask

  // Angle controller: done drops a cycle after the request, returns after latency
  initial begin
    int sidx;
    bus.done      = 1'b1;
    bus.angle     = 16'h0000;
    zero_position = 4'b0000;
    forever begin
      @(negedge clock);
      if (bus.read_angle === 1'b1) begin
        cur_id = bus.device_id;
        sidx   = int'(cur_id) - 32'h36;
        if (sidx < 0 || sidx > 3) sidx = 0;
        model_cycle();
        bus.done = 1'b0;
        if (hang_mode && sidx == 0) begin
          repeat (90) model_cycle();
          te_early = timeout_error[0];
          repeat (20) model_cycle();
          te_late   = timeout_error[0];
          hang_mode = 1'b0;
        end else begin
          repeat (latency) model_cycle();
        end
        bus.angle = angle_tab[sidx];
        bus.done  = 1'b1;
        if (zero_arm && sidx == 3) begin
          @(negedge clock);
          zero_position = 4'b1000;
          @(negedge clock);
          zero_position = 4'b0000;
          zero_arm      = 1'b0;
        end
      end
    end
  end

  // Request/sweep monitor
  always @(negedge clock) begin
    if (bus.read_angle === 1'b1) begin
      pulse_cnt++;
      ids_log = {ids_log[20:0], bus.device_id};
      if (bus.done !== 1'b1) overlap_cnt++;
    end
    if (sweep_done === 1'b1) sweep_cnt++;
  end

  task automatic wait_sweep(input string tag);
    int start;
    int n;
    start = sweep_cnt;
    n     = 0;
    while (sweep_cnt == start && n < 1500) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, "_seen"}, 128'(sweep_cnt != start), 128'd1);
    repeat (5) @(negedge clock);
    check_eq({tag, "_count"}, 128'(sweep_cnt - start), 128'd1);
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear_errors = 1'b1;
    @(negedge clock);
    clear_errors = 1'b0;
  endtask

  initial begin
    int p0;
    int s0;
    reset        = 1'b1;
    enable       = 1'b0;
    clear_errors = 1'b0;
    device_ids   = {7'h39, 7'h38, 7'h37, 7'h36};
    angle_tab    = '{16'h0123, 16'h0FFA, 16'h0005, 16'h0032};
    repeat (3) @(negedge clock);
    check_eq("rst_read_angle", 128'(bus.read_angle), 128'd0);
    check_eq("rst_device_id", 128'(bus.device_id), 128'h36);
    check_eq("rst_sweep_done", 128'(sweep_done), 128'd0);
    check_eq("rst_overrun", 128'(overrun), 128'd0);
    check_eq("rst_position", position, 128'd0);
    check_eq("rst_raw", 128'(raw_angle), 128'd0);
    check_eq("rst_valid", 128'(valid), 128'd0);
    check_eq("rst_timeout", 128'(timeout_error), 128'd0);
    reset  = 1'b0;
    enable = 1'b1;

    // Sweep 1: 50-cycle latency makes the sweep outlast the 200-cycle tick
    p0 = pulse_cnt;
    wait_sweep("sweep1");
    check_eq("s1_pulses", 128'(pulse_cnt - p0), 128'd4);
    check_eq("s1_id_order", 128'(ids_log), 128'({7'h36, 7'h37, 7'h38, 7'h39}));
    check_eq("s1_valid", 128'(valid), 128'hF);
    check_eq("s1_position", position, 128'd0);
    check_eq("s1_raw", 128'(raw_angle), 128'({16'h0032, 16'h0005, 16'h0FFA, 16'h0123}));
    check_eq("s1_overrun", 128'(overrun), 128'd1);
    pulse_clear();
    check_eq("s1_overrun_cleared", 128'(overrun), 128'd0);

    // Sweep 2: forward/reverse wrap, zero coinciding with sensor 3 update
    latency   = 10;
    zero_arm  = 1'b1;
    angle_tab = '{16'h0200, 16'h0005, 16'h0FFA, 16'h0064};
    p0 = pulse_cnt;
    wait_sweep("sweep2");
    check_eq("s2_pulses", 128'(pulse_cnt - p0), 128'd4);
    check_eq("s2_position", position,
             {32'h0000_0000, 32'hFFFF_FFF5, 32'h0000_000B, 32'h0000_00DD});
    check_eq("s2_raw", 128'(raw_angle), 128'({16'h0064, 16'h0FFA, 16'h0005, 16'h0200}));
    check_eq("s2_overrun", 128'(overrun), 128'd0);

    // Sweep 3: sensor 0 times out, the rest continue after recovery
    hang_mode = 1'b1;
    angle_tab = '{16'h0FFF, 16'h000A, 16'h0FFA, 16'hA06E};
    p0 = pulse_cnt;
    wait_sweep("sweep3");
    check_eq("s3_pulses", 128'(pulse_cnt - p0), 128'd4);
    check_eq("s3_tmo_before", 128'(te_early), 128'd0);
    check_eq("s3_tmo_after", 128'(te_late), 128'd1);
    check_eq("s3_timeout", 128'(timeout_error), 128'h1);
    check_eq("s3_valid", 128'(valid), 128'hF);
    check_eq("s3_position", position,
             {32'h0000_000A, 32'hFFFF_FFF5, 32'h0000_0010, 32'h0000_00DD});
    check_eq("s3_raw", 128'(raw_angle), 128'({16'hA06E, 16'h0FFA, 16'h000A, 16'h0200}));
    pulse_clear();
    check_eq("s3_timeout_cleared", 128'(timeout_error), 128'd0);

    check_eq("id_stable", 128'(id_glitch), 128'd0);
    check_eq("no_overlap", 128'(overlap_cnt), 128'd0);

    // Disabled: no sweep may start across two tick periods
    enable = 1'b0;
    p0 = pulse_cnt;
    s0 = sweep_cnt;
    repeat (450) @(negedge clock);
    check_eq("dis_pulses", 128'(pulse_cnt - p0), 128'd0);
    check_eq("dis_sweeps", 128'(sweep_cnt - s0), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/a1335_poll_scheduler.md
Name: a1335_poll_scheduler

Overview:
- Upstream sequencer and downstream consumer for the A1335 angle-read controller in myo_control.
- Periodically sweeps NUM_SENSORS A1335 encoders on one shared I2C controller. For each sensor it drives device_id, pulses read_angle, waits for the done handshake and captures the 16-bit angle.
- Unwraps the 12-bit angle into a signed 32-bit multi-turn position per sensor.
- Supervises each transaction with a timeout and reports sweep overruns.

Parameters:
NUM_SENSORS, 4, number of encoders polled per sweep
CLOCK_FREQ, 50000000, clock frequency in Hz
POLL_HZ, 1000, sweep start rate
TIMEOUT_CYCLES, 100000, maximum cycles from read_angle to done rising
ANGLE_BITS, 12, valid angle LSBs of the angle word

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  allows new sweeps to start
device_ids  in  7*NUM_SENSORS  I2C address of sensor i in bits [7i+6:7i]
clear_errors  in  1  clears timeout_error and overrun
zero_position  in  NUM_SENSORS  per-sensor position zeroing request
read_angle  out  1  one-cycle request pulse to the angle controller
device_id  out  7  address presented to the controller
done  in  1  controller idle/complete flag (1 = idle)
angle  in  16  angle word from the controller, valid when done rises
position  out  32*NUM_SENSORS  signed unwrapped position per sensor
raw_angle  out  16*NUM_SENSORS  last captured angle word per sensor
valid  out  NUM_SENSORS  sensor has at least one good sample since reset
timeout_error  out  NUM_SENSORS  sticky per-sensor timeout flag
overrun  out  1  sticky: a tick arrived while a sweep was still running
sweep_done  out  1  one-cycle pulse at the end of every sweep

Behaviour:
- Reset values:
  - read_angle=0, device_id=device_ids[6:0], sweep_done=0, overrun=0.
  - All position=0, raw_angle=0, valid=0, timeout_error=0.
  - FSM in IDLE, prescaler=0, index=0.
- Prescaler:
  - Counts 0..CLOCK_FREQ/POLL_HZ-1 continuously, independent of enable.
  - Emits an internal one-cycle tick on wrap.
- FSM states: IDLE, REQUEST, WAIT_BUSY, WAIT_DONE, UPDATE, RECOVER, NEXT.
  - IDLE: on tick && enable, set index=0 and go to REQUEST.
  - REQUEST:
    - If done=1: drive device_id=device_ids[index] and read_angle=1 for exactly this cycle, clear the timeout counter, go to WAIT_BUSY.
    - If done=0: stay in REQUEST, no pulse.
  - WAIT_BUSY: wait for done=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for done=1, then go to UPDATE.
  - UPDATE: capture angle (one cycle after done rises), update sensor[index], go to NEXT.
  - NEXT:
    - If index=NUM_SENSORS-1: pulse sweep_done and go to IDLE.
    - Otherwise: index+1, go to REQUEST.
  - RECOVER: wait for done=1, then go to NEXT with no data update.
- device_id is held stable from REQUEST until the state after UPDATE or RECOVER.
- Timeout:
  - The counter runs in WAIT_BUSY and WAIT_DONE.
  - Reaching TIMEOUT_CYCLES sets timeout_error[index]=1 and goes to RECOVER.
  - valid and position are left unchanged.
- Unwrap (in UPDATE):
  - a = angle[ANGLE_BITS-1:0].
  - If valid[index]=0: position=0, last=a, valid=1.
  - Otherwise: delta = (a - last) taken modulo 2^ANGLE_BITS, interpreted as a signed ANGLE_BITS value, sign-extended to 32 bits and added to position. Then last=a.
  - position wraps at 32 bits with no saturation.
  - raw_angle[index]=angle (full 16 bits).
- zero_position[i]:
  - Sets position[i]=0 and keeps last[i].
  - If it coincides with UPDATE for the same sensor: position=0, last=new a, valid=1 (zero wins).
- Overrun: a tick seen in any state other than IDLE sets overrun=1. The tick is dropped; sweeps never queue.
- enable deasserted mid-sweep: the current sweep completes. No new sweep starts.
- clear_errors:
  - Clears timeout_error and overrun.
  - A set event in the same cycle wins (flag stays 1).
- Reset mid-transaction: return to IDLE immediately. The controller is allowed to finish on its own; REQUEST waits for done=1 before pulsing again.

Decomposition:
- Shared package myo_pkg holds:
  - A1335_ANGLE_BITS=12, A1335_ADDR_W=7.
  - The FSM state encoding constants.
  - The position width constant POS_W=32.
- One natural sub-module, angle_unwrap: combinational delta computation plus a per-sensor position/last register, instantiated NUM_SENSORS times or shared through an index mux.

Test Plan:
- Single sensor, POLL_HZ scaled so tick=200 cycles; controller model drops done 1 cycle after read_angle and raises it 50 cycles later with angle=16'h0123 -> read_angle one pulse, device_id stable throughout, valid[0]=1, position[0]=0, raw_angle[0]=16'h0123, sweep_done pulse.
- Forward wrap: sequence 4090, 5, 10 -> position 0, +11, +16. Reverse sequence 5, 4090 -> position 0, -11.
- Controller never raises done, TIMEOUT_CYCLES=100 -> timeout_error[i]=1 after 100 cycles, RECOVER entered, sensor i+1 polled once done returns; clear_errors clears the flag.
- Four sensors with IDs 0x36, 0x37, 0x38, 0x39 -> four read_angle pulses in ascending ID order per sweep and exactly one sweep_done per sweep.
- Controller latency longer than the tick period -> overrun=1, no overlapping read_angle pulses.
- zero_position[0] asserted in the same cycle as UPDATE with angle 100 -> position[0]=0; the next angle 110 gives position[0]=+10.
